prio_span_packer: RTL and testbench
===================================

// Module: prio_span_packer
// PURPOSE
//   Downstream consumer of priority_encoder. Converts its one-hot left/right outputs
//   into binary bit indices and a span (number of bit positions from right to left).
//   Checks that each vector is one-hot and queues the results in a FIFO.
//   Hands results to the next stage over a valid/ready handshake.
//   The encoder cannot be stalled, so the FIFO absorbs bursts. Overflow drops are counted.
// PARAMETERS
//   WIDTH  16  width of data_left_i/data_right_i; must equal the encoder WIDTH (>=2)
//   DEPTH  8   FIFO entries; power of 2, >=2
//   IDX_W  localparam = $clog2(WIDTH); width of a bit index
// PORTS
//   clk_i         in   1        single clock, rising edge
//   arst_n_i      in   1        reset, asynchronous assert, active-low
//   data_left_i   in   WIDTH    one-hot MSB-most set bit from encoder
//   data_right_i  in   WIDTH    one-hot LSB-most set bit from encoder
//   data_val_i    in   1        input qualifier; no backpressure to encoder
//   left_idx_o    out  IDX_W    binary index of left bit
//   right_idx_o   out  IDX_W    binary index of right bit
//   span_o        out  IDX_W+1  left_idx - right_idx + 1; 0 for empty vector
//   zero_o        out  1        both input vectors were all-zero
//   err_o         out  1        malformed input (see BEHAVIOUR)
//   valid_o       out  1        head-of-FIFO entry valid
//   ready_i       in   1        downstream accepts when valid_o && ready_i
//   overflow_o    out  1        sticky: at least one entry was dropped
//   drop_cnt_o    out  16       saturating count of dropped entries
// BEHAVIOUR
//   Reset (arst_n_i=0, async): all outputs 0, FIFO emptied, stage-1 valid cleared.
//     Reset mid-operation discards all queued and in-flight entries.
//   Stage 1, edge after data_val_i=1: register the conversion results.
//     Each index = position of the set bit in its one-hot vector (0 when the vector is zero).
//     span = left_idx - right_idx + 1, computed in IDX_W+1 bits.
//     zero = both vectors all-zero. span=0 and idx=0 when zero=1.
//     err = either vector has >1 bit set,
//       OR exactly one vector is zero,
//       OR left_idx < right_idx.
//     When err=1, span is forced to 0. Indices hold the lowest set bit of each vector.
//   Stage 2, next edge: stage-1 entry {left,right,span,zero,err} is pushed into the FIFO.
//   Latency: data_val_i sampled at edge N -> valid_o=1 after edge N+2 if the FIFO was empty.
//   Back-to-back inputs (data_val_i every cycle) are accepted at full rate.
//   FIFO is show-ahead: outputs show the head entry whenever valid_o=1.
//     Outputs hold stable while valid_o && !ready_i.
//     Pop on valid_o && ready_i.
//     Output data fields are don't-care when valid_o=0.
//   Full, push without pop: entry is dropped.
//     overflow_o<=1 (sticky until reset).
//     drop_cnt_o increments and saturates at 16'hFFFF.
//   Full, push and pop in the same cycle: both succeed, no drop, occupancy unchanged.
//   Empty, push: there is no same-cycle bypass; valid_o rises on the following edge.
//   Read/write pointers wrap modulo DEPTH. Occupancy counter is IDX of $clog2(DEPTH)+1 bits.
//   Ordering is strictly FIFO. No entry is duplicated or reordered.
// TESTING
//   1 left=16'h0100, right=16'h0004, val 1 cycle, ready=1
//       -> 2 cycles later valid_o=1, left_idx=8, right_idx=2, span=7, err=0, zero=0
//   2 left=16'h0000, right=16'h0000
//       -> zero_o=1, span_o=0, err_o=0
//   3 Malformed inputs:
//       left=16'h0003, right=16'h0001 -> err_o=1, span_o=0
//       left=16'h0001, right=16'h0008 -> err_o=1
//   4 ready_i=0, 10 back-to-back inputs with left=1<<k, right=1 (k=0..9)
//       -> 8 entries held, overflow_o=1, drop_cnt_o=2
//       -> after ready_i=1, pops give left_idx 0..7 in order, span_o=1..8
//   5 FIFO full, ready_i=1 and data_val_i=1 in the same cycle
//       -> no drop, drop_cnt_o unchanged, valid_o stays 1
//   6 arst_n_i pulsed low mid-burst, asynchronously between edges
//       -> outputs 0 immediately, FIFO empty, overflow_o=0
//       -> next input appears 2 cycles after it is sampled

Source files
------------

// File: rtl/prio_span_packer.sv
// Converts one-hot left/right encoder outputs into bit indices, span and error flags,
// then queues the results in a show-ahead FIFO drained over a valid/ready handshake.
module prio_span_packer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
    input  logic             data_val_i,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic [IDX_W:0]   span_o,
    output logic             zero_o,
    output logic             err_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overflow_o,
    output logic [15:0]      drop_cnt_o
);

    localparam int unsigned SPAN_W = IDX_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [IDX_W-1:0]  left;
        logic [IDX_W-1:0]  right;
        logic [SPAN_W-1:0] span;
        logic              zero;
        logic              err;
    } entry_t;

    // Position of the lowest set bit; 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] low_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    entry_t            conv_c;
    logic              l_zero, r_zero, l_multi, r_multi;

    logic              s1_valid_q, s1_valid_d;
    entry_t            s1_q, s1_d;
    logic              s2_valid_q, s2_valid_d;
    entry_t            s2_q, s2_d;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              valid_c, full_c, push_c, pop_c, wr_en_c, drop_c;

    // Combinational conversion of the raw encoder vectors.
    always_comb begin
        l_zero       = (data_left_i == '0);
        r_zero       = (data_right_i == '0);
        l_multi      = ((data_left_i & (data_left_i - WIDTH'(1))) != '0);
        r_multi      = ((data_right_i & (data_right_i - WIDTH'(1))) != '0);
        conv_c.left  = low_idx(data_left_i);
        conv_c.right = low_idx(data_right_i);
        conv_c.zero  = l_zero & r_zero;
        conv_c.err   = l_multi | r_multi | (l_zero ^ r_zero) | (conv_c.left < conv_c.right);
        conv_c.span  = (conv_c.err | conv_c.zero) ? '0
                     : SPAN_W'(conv_c.left) - SPAN_W'(conv_c.right) + SPAN_W'(1);
    end

    // Two-stage pipeline feeding the FIFO write port.
    always_comb begin
        s1_valid_d = data_val_i;
        s1_d       = data_val_i ? conv_c : s1_q;
        s2_valid_d = s1_valid_q;
        s2_d       = s1_valid_q ? s1_q : s2_q;
    end

    // FIFO control: a push into a full FIFO only lands when a pop frees the slot.
    always_comb begin
        valid_c    = (cnt_q != '0);
        full_c     = (cnt_q == CNT_W'(DEPTH));
        pop_c      = valid_c & ready_i;
        push_c     = s2_valid_q;
        wr_en_c    = push_c & (~full_c | pop_c);
        drop_c     = push_c & full_c & ~pop_c;

        mem_d      = mem_q;
        if (wr_en_c) mem_d[wr_ptr_q] = s2_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        cnt_d      = cnt_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        overflow_d = overflow_q | drop_c;
        drop_cnt_d = (drop_c && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign valid_o     = valid_c;
    assign left_idx_o  = mem_q[rd_ptr_q].left;
    assign right_idx_o = mem_q[rd_ptr_q].right;
    assign span_o      = mem_q[rd_ptr_q].span;
    assign zero_o      = mem_q[rd_ptr_q].zero;
    assign err_o       = mem_q[rd_ptr_q].err;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_prio_span_packer.sv
// Bench for prio_span_packer: directed table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_prio_span_packer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk_i = 1'b0;
    logic             arst_n_i;
    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_val_i;
    logic [IDX_W-1:0] left_idx_o;
    logic [IDX_W-1:0] right_idx_o;
    logic [IDX_W:0]   span_o;
    logic             zero_o;
    logic             err_o;
    logic             valid_o;
    logic             ready_i;
    logic             overflow_o;
    logic [15:0]      drop_cnt_o;

    prio_span_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .data_left_i(data_left_i), .data_right_i(data_right_i), .data_val_i(data_val_i),
        .left_idx_o(left_idx_o), .right_idx_o(right_idx_o), .span_o(span_o),
        .zero_o(zero_o), .err_o(err_o), .valid_o(valid_o), .ready_i(ready_i),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int l;
        int r;
        int span;
        bit zero;
        bit err;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
        int               l;
        int               r;
        int               span;
        bit               zero;
        bit               err;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t mq[$];
    bit   dl_v[2];
    exp_t dl_e[2];
    bit   m_ovf;
    int   m_drops;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_conv(input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] rv);
        exp_t e;
        int   lo_l, lo_r;
        lo_l = 0;
        lo_r = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (lv[i]) lo_l = i;
            if (rv[i]) lo_r = i;
        end
        e.l    = lo_l;
        e.r    = lo_r;
        e.zero = (lv == 0) && (rv == 0);
        e.err  = ($countones(lv) > 1) || ($countones(rv) > 1) ||
                 ((lv == 0) != (rv == 0)) || (lo_l < lo_r);
        e.span = (e.err || e.zero) ? 0 : lo_l - lo_r + 1;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        dl_v[0] = 0;
        dl_v[1] = 0;
        m_ovf   = 0;
        m_drops = 0;
    endtask

    // Entry sampled at edge N joins the queue at edge N+2.
    task automatic model_step();
        bit popping;
        int pre;
        pre     = mq.size();
        popping = (pre > 0) && ready_i;
        if (popping) void'(mq.pop_front());
        if (dl_v[1]) begin
            if (pre < DEPTH || popping) mq.push_back(dl_e[1]);
            else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        dl_v[1] = dl_v[0];
        dl_e[1] = dl_e[0];
        dl_v[0] = data_val_i;
        dl_e[0] = ref_conv(data_left_i, data_right_i);
    endtask

    task automatic check_model();
        chk("model_valid", int'(valid_o), int'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("model_left", int'(left_idx_o), mq[0].l);
            chk("model_right", int'(right_idx_o), mq[0].r);
            chk("model_span", int'(span_o), mq[0].span);
            chk("model_zero", int'(zero_o), int'(mq[0].zero));
            chk("model_err", int'(err_o), int'(mq[0].err));
        end
        chk("model_overflow", int'(overflow_o), int'(m_ovf));
        chk("model_drops", int'(drop_cnt_o), m_drops);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        check_model();
    endtask

    task automatic drive(input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] rv, input logic v);
        data_left_i  = lv;
        data_right_i = rv;
        data_val_i   = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tbl[9];

    initial begin
        tbl[0] = '{16'h0100, 16'h0004,  8, 2,  7, 0, 0};
        tbl[1] = '{16'h0000, 16'h0000,  0, 0,  0, 1, 0};
        tbl[2] = '{16'h0003, 16'h0001,  0, 0,  0, 0, 1};
        tbl[3] = '{16'h0001, 16'h0008,  0, 3,  0, 0, 1};
        tbl[4] = '{16'h8000, 16'h0001, 15, 0, 16, 0, 0};
        tbl[5] = '{16'h0000, 16'h0010,  0, 4,  0, 0, 1};
        tbl[6] = '{16'h0020, 16'h0020,  5, 5,  1, 0, 0};
        tbl[7] = '{16'h8000, 16'h8000, 15, 15, 1, 0, 0};
        tbl[8] = '{16'h0101, 16'h0100,  0, 8,  0, 0, 1};

        model_reset();
        arst_n_i = 1'b0;
        ready_i  = 1'b1;
        drive('0, '0, 1'b0);
        #1;
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_span", int'(span_o), 0);
        chk("reset_overflow", int'(overflow_o), 0);
        chk("reset_drops", int'(drop_cnt_o), 0);
        @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;

        // Directed conversion table with latency checks.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].left, tbl[i].right, 1'b1);
            tick();
            drive('0, '0, 1'b0);
            tick();
            chk("tbl_latency_early", int'(valid_o), 0);
            tick();
            chk("tbl_valid", int'(valid_o), 1);
            chk("tbl_left", int'(left_idx_o), tbl[i].l);
            chk("tbl_right", int'(right_idx_o), tbl[i].r);
            chk("tbl_span", int'(span_o), tbl[i].span);
            chk("tbl_zero", int'(zero_o), int'(tbl[i].zero));
            chk("tbl_err", int'(err_o), int'(tbl[i].err));
            tick();
        end

        // Overflow: ten inputs into a stalled eight-entry FIFO.
        ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(WIDTH'(1) << k, WIDTH'(1), 1'b1);
            tick();
        end
        drive('0, '0, 1'b0);
        repeat (3) tick();
        chk("ovf_sticky", int'(overflow_o), 1);
        chk("ovf_drops", int'(drop_cnt_o), 2);
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_order_left", int'(left_idx_o), k);
            chk("ovf_order_span", int'(span_o), k + 1);
            tick();
        end
        chk("ovf_drained", int'(valid_o), 0);

        // Full FIFO with simultaneous push and pop.
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(WIDTH'(1) << (k + 2), WIDTH'(1) << k, 1'b1);
            tick();
        end
        drive(16'h4000, 16'h0002, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("full_pp_drops", int'(drop_cnt_o), 2);
        chk("full_pp_valid", int'(valid_o), 1);
        chk("full_pp_head", int'(left_idx_o), 3);
        repeat (2) tick();
        ready_i = 1'b1;
        repeat (10) tick();
        chk("full_pp_drained", int'(valid_o), 0);

        // Asynchronous reset mid-burst, away from the clock edge.
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(16'h0800, WIDTH'(1) << k, 1'b1);
            tick();
        end
        #3;
        arst_n_i = 1'b0;
        #1;
        chk("arst_valid", int'(valid_o), 0);
        chk("arst_overflow", int'(overflow_o), 0);
        chk("arst_drops", int'(drop_cnt_o), 0);
        chk("arst_left", int'(left_idx_o), 0);
        chk("arst_span", int'(span_o), 0);
        model_reset();
        drive('0, '0, 1'b0);
        @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        ready_i  = 1'b1;
        drive(16'h0100, 16'h0004, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        tick();
        chk("post_rst_early", int'(valid_o), 0);
        tick();
        chk("post_rst_valid", int'(valid_o), 1);
        chk("post_rst_span", int'(span_o), 7);
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            logic [WIDTH-1:0] lv, rv;
            int               a, b, mode;
            mode = $urandom_range(0, 3);
            a    = $urandom_range(0, WIDTH - 1);
            b    = $urandom_range(0, WIDTH - 1);
            case (mode)
                0: begin
                    lv = WIDTH'(1) << ((a > b) ? a : b);
                    rv = WIDTH'(1) << ((a > b) ? b : a);
                end
                1: begin
                    lv = '0;
                    rv = '0;
                end
                2: begin
                    lv = WIDTH'(1) << a;
                    rv = WIDTH'(1) << b;
                end
                default: begin
                    lv = WIDTH'($urandom());
                    rv = WIDTH'($urandom());
                end
            endcase
            drive(lv, rv, 1'($urandom_range(0, 1)));
            ready_i = ($urandom_range(0, 2) != 0);
            tick();
        end
        drive('0, '0, 1'b0);
        ready_i = 1'b1;
        repeat (12) tick();
        chk("final_drained", int'(valid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
